// File: rtl/wb_dcache_write_buffer.sv
// Store buffer between the writeback stage and the dcache write port.
// In-order FIFO drain with req/ack handshake and load-overlap detection.
module wb_dcache_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              WB_wr_valid,
    input  logic [ADDR_W-1:0] WB_wr_addr,
    input  logic [DATA_W-1:0] WB_wr_data,
    input  logic [1:0]        WB_wr_size,
    output logic              Out_write_ready,
    output logic              DC_wr_req,
    output logic [ADDR_W-1:0] DC_wr_addr,
    output logic [DATA_W-1:0] DC_wr_data,
    output logic [1:0]        DC_wr_size,
    input  logic              DC_wr_ack,
    input  logic [ADDR_W-1:0] LD_addr,
    output logic              LD_conflict,
    output logic              BUF_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;

    logic [ADDR_W-1:0]  addr_q [DEPTH];
    logic [ADDR_W-1:0]  addr_d [DEPTH];
    logic [DATA_W-1:0]  data_q [DEPTH];
    logic [DATA_W-1:0]  data_d [DEPTH];
    logic [1:0]         size_q [DEPTH];
    logic [1:0]         size_d [DEPTH];

    logic               push;
    logic               pop;
    logic [PTR_W-1:0]   off;
    logic               hit;

    // Handshake, pointer/count update, FSM next state and drain outputs
    always_comb begin
        Out_write_ready = (count_q != FULL_CNT) && !RST;
        DC_wr_req       = (state_q == ISSUE) && !RST;
        push            = WB_wr_valid && Out_write_ready;
        pop             = DC_wr_req && DC_wr_ack;

        DC_wr_addr = '0;
        DC_wr_data = '0;
        DC_wr_size = '0;
        if (DC_wr_req) begin
            DC_wr_addr = addr_q[rd_ptr_q];
            DC_wr_data = data_q[rd_ptr_q];
            DC_wr_size = size_q[rd_ptr_q];
        end

        addr_d   = addr_q;
        data_d   = data_q;
        size_d   = size_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            addr_d[wr_ptr_q] = WB_wr_addr;
            data_d[wr_ptr_q] = WB_wr_data;
            size_d[wr_ptr_q] = WB_wr_size;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (count_q != '0) state_d = ISSUE;
            end
            ISSUE: begin
                if (pop && (count_d == '0)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        BUF_empty = (count_q == '0) || RST;
    end

    // Load overlap: any live entry in the same 8-byte block as the load
    always_comb begin
        hit = 1'b0;
        off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PTR_W'(i) - rd_ptr_q;
            if (({1'b0, off} < count_q) &&
                (addr_q[i][ADDR_W-1:3] == LD_addr[ADDR_W-1:3])) begin
                hit = 1'b1;
            end
        end
        LD_conflict = hit && !RST;
    end

    // Control state with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Entry storage; contents are only meaningful under count
    always_ff @(posedge CLK) begin
        addr_q <= addr_d;
        data_q <= data_d;
        size_q <= size_d;
    end

endmodule

// File: tb/tb_wb_dcache_write_buffer.sv
// Directed self-checking bench for wb_dcache_write_buffer.
// Linear stimulus with hand-computed expectations.
module tb_wb_dcache_write_buffer;

    logic        CLK;
    logic        RST;
    logic        WB_wr_valid;
    logic [31:0] WB_wr_addr;
    logic [63:0] WB_wr_data;
    logic [1:0]  WB_wr_size;
    logic        Out_write_ready;
    logic        DC_wr_req;
    logic [31:0] DC_wr_addr;
    logic [63:0] DC_wr_data;
    logic [1:0]  DC_wr_size;
    logic        DC_wr_ack;
    logic [31:0] LD_addr;
    logic        LD_conflict;
    logic        BUF_empty;

    int n_cmp = 0;
    int n_bad = 0;
    int popped;
    logic [31:0] exp_addr [8];
    logic [63:0] exp_data [8];

    wb_dcache_write_buffer #(
        .DEPTH (4),
        .ADDR_W(32),
        .DATA_W(64)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .WB_wr_valid    (WB_wr_valid),
        .WB_wr_addr     (WB_wr_addr),
        .WB_wr_data     (WB_wr_data),
        .WB_wr_size     (WB_wr_size),
        .Out_write_ready(Out_write_ready),
        .DC_wr_req      (DC_wr_req),
        .DC_wr_addr     (DC_wr_addr),
        .DC_wr_data     (DC_wr_data),
        .DC_wr_size     (DC_wr_size),
        .DC_wr_ack      (DC_wr_ack),
        .LD_addr        (LD_addr),
        .LD_conflict    (LD_conflict),
        .BUF_empty      (BUF_empty)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST         = 1'b1;
        WB_wr_valid = 1'b1;
        WB_wr_addr  = 32'h999;
        WB_wr_data  = 64'h1;
        WB_wr_size  = 2'b00;
        DC_wr_ack   = 1'b0;
        LD_addr     = 32'h998;

        // Reset held two edges with a valid request present
        tick();
        tick();
        chk("rst_ready", Out_write_ready, 0);
        chk("rst_req", DC_wr_req, 0);
        chk("rst_empty", BUF_empty, 1);
        chk("rst_conf", LD_conflict, 0);
        RST         = 1'b0;
        WB_wr_valid = 1'b0;
        #1;
        chk("rel_ready", Out_write_ready, 1);
        chk("rel_empty", BUF_empty, 1);
        tick();
        chk("rel_req", DC_wr_req, 0);
        chk("rel_empty2", BUF_empty, 1);

        // Single store, held three cycles, then acked
        WB_wr_valid = 1'b1;
        WB_wr_addr  = 32'h1000;
        WB_wr_data  = 64'hDEADBEEF;
        WB_wr_size  = 2'b10;
        tick();
        WB_wr_valid = 1'b0;
        WB_wr_addr  = 32'h0;
        WB_wr_data  = 64'h0;
        WB_wr_size  = 2'b00;
        chk("s_req0", DC_wr_req, 0);
        chk("s_empty0", BUF_empty, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("s_req", DC_wr_req, 1);
            chk("s_addr", DC_wr_addr, 64'h1000);
            chk("s_data", DC_wr_data, 64'hDEADBEEF);
            chk("s_size", DC_wr_size, 2);
        end
        DC_wr_ack = 1'b1;
        tick();
        DC_wr_ack = 1'b0;
        chk("s_req_drop", DC_wr_req, 0);
        chk("s_empty1", BUF_empty, 1);
        chk("s_addr0", DC_wr_addr, 0);

        // Fill to full, stall the fifth store, release with one ack
        for (int i = 0; i < 4; i++) begin
            WB_wr_valid = 1'b1;
            WB_wr_addr  = 32'h10 * (i + 1);
            WB_wr_data  = 64'h100 + i;
            WB_wr_size  = 2'b01;
            tick();
        end
        chk("f_ready_full", Out_write_ready, 0);
        chk("f_head", DC_wr_addr, 64'h10);
        WB_wr_addr = 32'h50;
        WB_wr_data = 64'h104;
        tick();
        chk("f_stall_ready", Out_write_ready, 0);
        chk("f_stall_head", DC_wr_addr, 64'h10);
        DC_wr_ack = 1'b1;
        #1;
        chk("f_nobypass", Out_write_ready, 0);
        tick();
        DC_wr_ack = 1'b0;
        chk("f_ready_free", Out_write_ready, 1);
        chk("f_head2", DC_wr_addr, 64'h20);
        tick();
        WB_wr_valid = 1'b0;
        chk("f_full_again", Out_write_ready, 0);
        DC_wr_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("f_order_req", DC_wr_req, 1);
            chk("f_order_addr", DC_wr_addr, 32'h20 + 32'h10 * i);
            chk("f_order_data", DC_wr_data, 64'h101 + i);
            tick();
        end
        DC_wr_ack = 1'b0;
        chk("f_req_end", DC_wr_req, 0);
        chk("f_empty_end", BUF_empty, 1);

        // Streaming: ack held while pushing every cycle
        for (int i = 0; i < 8; i++) begin
            exp_addr[i] = 32'h100 + 32'h8 * i;
            exp_data[i] = 64'hA0 + i;
        end
        popped    = 0;
        DC_wr_ack = 1'b1;
        for (int c = 0; c < 14; c++) begin
            if (c < 8) begin
                WB_wr_valid = 1'b1;
                WB_wr_addr  = exp_addr[c];
                WB_wr_data  = exp_data[c];
                WB_wr_size  = 2'b11;
                #1;
                chk("st_ready", Out_write_ready, 1);
            end else begin
                WB_wr_valid = 1'b0;
            end
            if (DC_wr_req) begin
                if (popped < 8) begin
                    chk("st_addr", DC_wr_addr, exp_addr[popped]);
                    chk("st_data", DC_wr_data, exp_data[popped]);
                end
                popped++;
            end
            tick();
        end
        DC_wr_ack   = 1'b0;
        WB_wr_valid = 1'b0;
        chk("st_popped", popped, 8);
        chk("st_empty", BUF_empty, 1);

        // Load conflict detection
        LD_addr     = 32'h2000;
        WB_wr_valid = 1'b1;
        WB_wr_addr  = 32'h2004;
        WB_wr_data  = 64'h55;
        WB_wr_size  = 2'b01;
        #1;
        chk("c_push_nohit", LD_conflict, 0);
        tick();
        WB_wr_valid = 1'b0;
        chk("c_hit", LD_conflict, 1);
        LD_addr = 32'h2008;
        #1;
        chk("c_miss_next", LD_conflict, 0);
        tick();
        LD_addr   = 32'h2000;
        DC_wr_ack = 1'b1;
        #1;
        chk("c_req", DC_wr_req, 1);
        chk("c_hit_popping", LD_conflict, 1);
        tick();
        DC_wr_ack = 1'b0;
        chk("c_after_ack", LD_conflict, 0);
        chk("c_empty", BUF_empty, 1);

        // Reset in the same cycle as an ack mid-drain
        for (int i = 0; i < 3; i++) begin
            WB_wr_valid = 1'b1;
            WB_wr_addr  = 32'h3000 + 32'h8 * i;
            WB_wr_data  = 64'h300 + i;
            tick();
        end
        WB_wr_valid = 1'b0;
        chk("m_req", DC_wr_req, 1);
        chk("m_head", DC_wr_addr, 64'h3000);
        LD_addr   = 32'h3000;
        RST       = 1'b1;
        DC_wr_ack = 1'b1;
        #1;
        chk("m_rst_req", DC_wr_req, 0);
        chk("m_rst_ready", Out_write_ready, 0);
        chk("m_rst_empty", BUF_empty, 1);
        chk("m_rst_conf", LD_conflict, 0);
        tick();
        RST       = 1'b0;
        DC_wr_ack = 1'b0;
        #1;
        chk("m_empty", BUF_empty, 1);
        chk("m_conf", LD_conflict, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("m_no_req", DC_wr_req, 0);
        end
        WB_wr_valid = 1'b1;
        WB_wr_addr  = 32'h4000;
        WB_wr_data  = 64'h400;
        tick();
        WB_wr_valid = 1'b0;
        tick();
        chk("m_fresh_req", DC_wr_req, 1);
        chk("m_fresh_addr", DC_wr_addr, 64'h4000);
        chk("m_fresh_data", DC_wr_data, 64'h400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
